ts_rx_detect: RTL and testbench

Receive-side ordered-set decoder for the 16-bit PIPE interface of the TI PHY design. Consumes the PHY's rxdata16/rxdatak16 stream in the rxclk domain and recognises TS1 and TS2 training sets: 16 symbols, 2 per word, low byte first, COM always in the low byte. Reports the link/lane/N_FTS/rate/training-control fields, counts consecutive identical sets, and flags inverted-polarity sets and framing/decode errors for the link-training logic.

---
 rtl/ts_rx_detect_if.sv | 35 +++
 rtl/ts_rx_detect.sv | 195 +++++++++++++++++++
 tb/tb_ts_rx_detect.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/ts_rx_detect_if.sv
// ts_rx_detect_if: PIPE 16-bit receive stream plus decoded training-set results.
//   master: drives rxdata16/rxdatak16/rxvalid16/rxstatus, observes results
//   slave : the decoder; consumes the rx stream, drives the detect/field outputs
interface ts_rx_detect_if #(
  parameter int CNT_W = 4
);
  logic [15:0]      rxdata16;    // [7:0] first symbol, [15:8] second
  logic [1:0]       rxdatak16;   // K flags per byte
  logic             rxvalid16;
  logic [2:0]       rxstatus;
  logic             ts1_det;
  logic             ts2_det;
  logic             ts_inv_det;
  logic             ts_err;
  logic [7:0]       link_num;
  logic [7:0]       lane_num;
  logic             link_pad;
  logic             lane_pad;
  logic [7:0]       n_fts;
  logic [7:0]       rate_id;
  logic [7:0]       train_ctrl;
  logic [CNT_W-1:0] consec_cnt;

  modport master (
    output rxdata16, rxdatak16, rxvalid16, rxstatus,
    input  ts1_det, ts2_det, ts_inv_det, ts_err, link_num, lane_num,
           link_pad, lane_pad, n_fts, rate_id, train_ctrl, consec_cnt
  );

  modport slave (
    input  rxdata16, rxdatak16, rxvalid16, rxstatus,
    output ts1_det, ts2_det, ts_inv_det, ts_err, link_num, lane_num,
           link_pad, lane_pad, n_fts, rate_id, train_ctrl, consec_cnt
  );
endinterface

// File: rtl/ts_rx_detect.sv
// ts_rx_detect: TS1/TS2 ordered-set decoder on a 16-bit PIPE receive stream.
// A set is 8 words (16 symbols), COM in the low byte of word 0. Fields are
// staged while the set arrives and copied to the outputs only when a valid
// TS1/TS2 completes. consec_cnt counts identical back-to-back accepted sets.
//   rxclk : receive clock, all logic on rising edge
//   reset : asynchronous, active-high
//   bus   : ts_rx_detect_if.slave (rx stream in, pulses/fields/count out)
module ts_rx_detect #(
  parameter int CNT_W = 4
) (
  input logic         rxclk,
  input logic         reset,
  ts_rx_detect_if.slave bus
);

  typedef enum logic [2:0] {IDLE, W1, W2, W3, W4, W5, W6, W7} state_t;

  localparam logic [7:0] K_COM = 8'hBC;
  localparam logic [7:0] K_PAD = 8'hF7;
  localparam logic [7:0] ID_TS1 = 8'h4A;
  localparam logic [7:0] ID_TS2 = 8'h45;
  localparam logic [7:0] ID_TS1_INV = 8'hB5;
  localparam logic [7:0] ID_TS2_INV = 8'hBA;

  state_t           r_state;
  logic             r_ts1, r_ts2, r_inv, r_err;
  logic [7:0]       r_link, r_lane, r_nfts, r_rate, r_tc;
  logic             r_link_pad, r_lane_pad;
  logic [CNT_W-1:0] r_consec;
  logic             r_chain;     // last accepted set is a valid base for counting
  logic             r_last_ts2;  // type of last accepted set
  // staging
  logic [7:0]       r_s_link, r_s_lane, r_s_nfts, r_s_rate, r_s_tc, r_s_id;
  logic             r_s_link_pad, r_s_lane_pad;

  logic [7:0] w_lo, w_hi;
  logic       w_klo, w_khi;
  logic       w_com, w_word_ok, w_hi_pad, w_hi_badk, w_lo_pad;
  logic       w_abort, w_start, w_restart, w_adv, w_done;
  logic       w_s_ts, w_s_ts2, w_same;

  function automatic logic f_id_legal(input logic [7:0] b);
    return (b == ID_TS1) || (b == ID_TS2) || (b == ID_TS1_INV) || (b == ID_TS2_INV);
  endfunction

  assign w_lo      = bus.rxdata16[7:0];
  assign w_hi      = bus.rxdata16[15:8];
  assign w_klo     = bus.rxdatak16[0];
  assign w_khi     = bus.rxdatak16[1];
  assign w_com     = w_klo && (w_lo == K_COM);
  assign w_word_ok = bus.rxvalid16 && (bus.rxstatus != 3'b100) && (bus.rxstatus != 3'b111);
  assign w_hi_pad  = w_khi && (w_hi == K_PAD);
  assign w_hi_badk = w_khi && (w_hi != K_PAD);
  assign w_lo_pad  = w_klo && (w_lo == K_PAD);

  // Per-word decode. IDLE never raises an error except for a COM word whose
  // link byte is an illegal K. A COM mid-set both flags an error and starts
  // the new set on the same word so no cycle is lost.
  always_comb begin
    w_abort   = 1'b0;
    w_start   = 1'b0;
    w_restart = 1'b0;
    w_adv     = 1'b0;
    if (r_state == IDLE) begin
      if (w_word_ok && w_com) begin
        if (w_hi_badk) w_abort = 1'b1;
        else           w_start = 1'b1;
      end
    end else if (!w_word_ok) begin
      w_abort = 1'b1;
    end else if (w_com) begin
      if (w_hi_badk) begin
        w_abort = 1'b1;
      end else begin
        w_start   = 1'b1;
        w_restart = 1'b1;
      end
    end else begin
      case (r_state)
        W1:      w_abort = (w_klo && !w_lo_pad) || w_khi;
        W2:      w_abort = w_klo || w_khi;
        W3:      w_abort = w_klo || w_khi || !f_id_legal(w_lo) || (w_hi != w_lo);
        default: w_abort = w_klo || w_khi || (w_lo != r_s_id) || (w_hi != r_s_id);
      endcase
      w_adv = !w_abort;
    end
  end

  assign w_done  = w_adv && (r_state == W7);
  assign w_s_ts2 = (r_s_id == ID_TS2);
  assign w_s_ts  = (r_s_id == ID_TS1) || w_s_ts2;
  assign w_same  = r_chain && (w_s_ts2 == r_last_ts2) &&
                   (r_s_link == r_link) && (r_s_lane == r_lane) &&
                   (r_s_nfts == r_nfts) && (r_s_rate == r_rate) && (r_s_tc == r_tc) &&
                   (r_s_link_pad == r_link_pad) && (r_s_lane_pad == r_lane_pad);

  always_ff @(posedge rxclk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_ts1        <= 1'b0;
      r_ts2        <= 1'b0;
      r_inv        <= 1'b0;
      r_err        <= 1'b0;
      r_link       <= '0;
      r_lane       <= '0;
      r_nfts       <= '0;
      r_rate       <= '0;
      r_tc         <= '0;
      r_link_pad   <= 1'b0;
      r_lane_pad   <= 1'b0;
      r_consec     <= '0;
      r_chain      <= 1'b0;
      r_last_ts2   <= 1'b0;
      r_s_link     <= '0;
      r_s_lane     <= '0;
      r_s_nfts     <= '0;
      r_s_rate     <= '0;
      r_s_tc       <= '0;
      r_s_id       <= '0;
      r_s_link_pad <= 1'b0;
      r_s_lane_pad <= 1'b0;
    end else begin
      r_ts1 <= 1'b0;
      r_ts2 <= 1'b0;
      r_inv <= 1'b0;
      r_err <= w_abort || w_restart;

      if (w_abort || w_restart) begin
        r_consec <= '0;
        r_chain  <= 1'b0;
      end
      if (w_abort) r_state <= IDLE;

      if (w_start) begin
        r_state      <= W1;
        r_s_link     <= w_hi_pad ? 8'h00 : w_hi;
        r_s_link_pad <= w_hi_pad;
      end

      if (w_adv) begin
        case (r_state)
          W1: begin
            r_s_lane     <= w_lo_pad ? 8'h00 : w_lo;
            r_s_lane_pad <= w_lo_pad;
            r_s_nfts     <= w_hi;
          end
          W2: begin
            r_s_rate <= w_lo;
            r_s_tc   <= w_hi;
          end
          W3:      r_s_id <= w_lo;
          default: ;
        endcase
        r_state <= (r_state == W7) ? IDLE : state_t'(r_state + 3'd1);
      end

      if (w_done) begin
        if (w_s_ts) begin
          r_ts1      <= !w_s_ts2;
          r_ts2      <= w_s_ts2;
          r_link     <= r_s_link;
          r_lane     <= r_s_lane;
          r_nfts     <= r_s_nfts;
          r_rate     <= r_s_rate;
          r_tc       <= r_s_tc;
          r_link_pad <= r_s_link_pad;
          r_lane_pad <= r_s_lane_pad;
          r_last_ts2 <= w_s_ts2;
          r_chain    <= 1'b1;
          if (w_same) r_consec <= (r_consec == '1) ? r_consec : r_consec + CNT_W'(1);
          else        r_consec <= CNT_W'(1);
        end else begin
          // inverted polarity: report only, break the identical-set run
          r_inv    <= 1'b1;
          r_consec <= '0;
          r_chain  <= 1'b0;
        end
      end
    end
  end

  assign bus.ts1_det    = r_ts1;
  assign bus.ts2_det    = r_ts2;
  assign bus.ts_inv_det = r_inv;
  assign bus.ts_err     = r_err;
  assign bus.link_num   = r_link;
  assign bus.lane_num   = r_lane;
  assign bus.link_pad   = r_link_pad;
  assign bus.lane_pad   = r_lane_pad;
  assign bus.n_fts      = r_nfts;
  assign bus.rate_id    = r_rate;
  assign bus.train_ctrl = r_tc;
  assign bus.consec_cnt = r_consec;

endmodule

// File: tb/tb_ts_rx_detect.sv
// Directed table-driven bench for ts_rx_detect. Pulses are encoded
// {ts1,ts2,inv,err}; each table row is one received word and the expected
// outputs one cycle later.
module tb_ts_rx_detect;

  logic rxclk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad   = 0;

  ts_rx_detect_if #(.CNT_W(4)) bus ();

  ts_rx_detect #(.CNT_W(4)) dut (
    .rxclk (rxclk),
    .reset (reset),
    .bus   (bus)
  );

  always #2 rxclk = ~rxclk;

  typedef struct {
    logic [15:0] d;
    logic [1:0]  k;
    logic        v;
    logic [2:0]  s;
    logic [3:0]  p;
    logic [3:0]  c;
  } vec_t;

  vec_t tbl[$];

  localparam logic [3:0] P0 = 4'b0000, PT1 = 4'b1000, PT2 = 4'b0100,
                         PINV = 4'b0010, PERR = 4'b0001;

  function automatic logic [3:0] pulses();
    return {bus.ts1_det, bus.ts2_det, bus.ts_inv_det, bus.ts_err};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [15:0] d, input logic [1:0] k, input logic v,
                     input logic [2:0] s, input logic [3:0] p, input logic [3:0] c);
    vec_t e;
    e.d = d; e.k = k; e.v = v; e.s = s; e.p = p; e.c = c;
    tbl.push_back(e);
  endtask

  // full 8-word set; count is cb during the set and ca after the last word
  task automatic add_set(input logic [15:0] w0, input logic [1:0] k0,
                         input logic [15:0] w1, input logic [1:0] k1,
                         input logic [15:0] idw, input logic [3:0] p,
                         input logic [3:0] cb, input logic [3:0] ca);
    add(w0, k0, 1'b1, 3'b000, P0, cb);
    add(w1, k1, 1'b1, 3'b000, P0, cb);
    add(16'h0002, 2'b00, 1'b1, 3'b000, P0, cb);
    for (int i = 0; i < 4; i++) add(idw, 2'b00, 1'b1, 3'b000, P0, cb);
    add(idw, 2'b00, 1'b1, 3'b000, p, ca);
  endtask

  task automatic add_ts1(input logic [3:0] cb, input logic [3:0] ca);
    add_set(16'hF7BC, 2'b11, 16'hF0F7, 2'b01, 16'h4A4A, PT1, cb, ca);
  endtask

  task automatic apply(input logic [15:0] d, input logic [1:0] k,
                       input logic v, input logic [2:0] s);
    bus.rxdata16  = d;
    bus.rxdatak16 = k;
    bus.rxvalid16 = v;
    bus.rxstatus  = s;
    @(posedge rxclk);
    #1;
  endtask

  task automatic run_table(input string tag);
    foreach (tbl[i]) begin
      apply(tbl[i].d, tbl[i].k, tbl[i].v, tbl[i].s);
      chk($sformatf("%s[%0d].pulses", tag, i), 32'(pulses()), 32'(tbl[i].p));
      chk($sformatf("%s[%0d].cnt", tag, i), 32'(bus.consec_cnt), 32'(tbl[i].c));
    end
    tbl.delete();
  endtask

  task automatic chk_pad_ts1_fields(input string tag);
    chk({tag, ".link_pad"}, 32'(bus.link_pad), 32'd1);
    chk({tag, ".lane_pad"}, 32'(bus.lane_pad), 32'd1);
    chk({tag, ".link_num"}, 32'(bus.link_num), 32'h00);
    chk({tag, ".lane_num"}, 32'(bus.lane_num), 32'h00);
    chk({tag, ".n_fts"},    32'(bus.n_fts),    32'hF0);
    chk({tag, ".rate_id"},  32'(bus.rate_id),  32'h02);
    chk({tag, ".train"},    32'(bus.train_ctrl), 32'h00);
  endtask

  function automatic logic [63:0] all_outs();
    return {pulses(), bus.link_num, bus.lane_num, bus.link_pad, bus.lane_pad,
            bus.n_fts, bus.rate_id, bus.train_ctrl, bus.consec_cnt};
  endfunction

  initial begin
    bus.rxdata16 = '0; bus.rxdatak16 = '0; bus.rxvalid16 = 1'b0; bus.rxstatus = '0;
    repeat (2) @(posedge rxclk);
    #1;
    chk("reset.outs", 32'(all_outs()), 32'd0);
    chk("reset.outs_hi", 32'(all_outs() >> 32), 32'd0);
    reset = 1'b0;
    apply(16'h0000, 2'b00, 1'b0, 3'b000);

    // three back-to-back identical TS1 with PAD link/lane
    add_ts1(4'd0, 4'd1);
    add_ts1(4'd1, 4'd2);
    add_ts1(4'd2, 4'd3);
    run_table("ts1x3");
    chk_pad_ts1_fields("ts1x3");

    // 20 identical TS2: first differs in type -> 1, saturates at 15
    for (int n = 1; n <= 20; n++)
      add_set(16'h05BC, 2'b01, 16'hF000, 2'b00, 16'h4545, PT2,
              (n == 1) ? 4'd3 : ((n - 1 > 15) ? 4'd15 : 4'(n - 1)),
              (n > 15) ? 4'd15 : 4'(n));
    run_table("ts2x20");
    chk("ts2.link_num", 32'(bus.link_num), 32'h05);
    chk("ts2.link_pad", 32'(bus.link_pad), 32'd0);
    chk("ts2.lane_pad", 32'(bus.lane_pad), 32'd0);
    add_ts1(4'd15, 4'd1);
    run_table("ts1_after_ts2");

    // ID mismatch in word 5; aborted set carries link 0x07 which must not leak
    add(16'h07BC, 2'b01, 1'b1, 3'b000, P0, 4'd1);
    add(16'hF0F7, 2'b01, 1'b1, 3'b000, P0, 4'd1);
    add(16'h0002, 2'b00, 1'b1, 3'b000, P0, 4'd1);
    add(16'h4A4A, 2'b00, 1'b1, 3'b000, P0, 4'd1);
    add(16'h4A4A, 2'b00, 1'b1, 3'b000, P0, 4'd1);
    add(16'h4A45, 2'b00, 1'b1, 3'b000, PERR, 4'd0);
    add(16'h4A4A, 2'b00, 1'b1, 3'b000, P0, 4'd0);
    add(16'h4A4A, 2'b00, 1'b1, 3'b000, P0, 4'd0);
    run_table("idmis");
    chk_pad_ts1_fields("idmis");
    add_ts1(4'd0, 4'd1);
    run_table("idmis_clean");

    // COM injected as word 4 restarts a set in place
    add(16'hF7BC, 2'b11, 1'b1, 3'b000, P0, 4'd1);
    add(16'hF0F7, 2'b01, 1'b1, 3'b000, P0, 4'd1);
    add(16'h0002, 2'b00, 1'b1, 3'b000, P0, 4'd1);
    add(16'h4A4A, 2'b00, 1'b1, 3'b000, P0, 4'd1);
    add(16'hF7BC, 2'b11, 1'b1, 3'b000, PERR, 4'd0);
    add(16'hF0F7, 2'b01, 1'b1, 3'b000, P0, 4'd0);
    add(16'h0002, 2'b00, 1'b1, 3'b000, P0, 4'd0);
    for (int i = 0; i < 4; i++) add(16'h4A4A, 2'b00, 1'b1, 3'b000, P0, 4'd0);
    add(16'h4A4A, 2'b00, 1'b1, 3'b000, PT1, 4'd1);
    add_ts1(4'd1, 4'd2);
    run_table("com_mid");

    // inverted IDs: report only, fields held (link 0x09 must not appear)
    add_set(16'h09BC, 2'b01, 16'hF0F7, 2'b01, 16'hB5B5, PINV, 4'd2, 4'd0);
    run_table("inv");
    chk_pad_ts1_fields("inv");
    add_ts1(4'd0, 4'd1);
    run_table("inv_clean");

    // IDLE noise, rxvalid16 drop, rxstatus disparity error
    add(16'h1234, 2'b00, 1'b1, 3'b000, P0, 4'd1);
    add(16'hBC00, 2'b10, 1'b1, 3'b000, P0, 4'd1);
    add(16'hF7BC, 2'b11, 1'b0, 3'b000, P0, 4'd1);
    add(16'hF7BC, 2'b11, 1'b1, 3'b111, P0, 4'd1);
    add(16'hF7BC, 2'b11, 1'b1, 3'b000, P0, 4'd1);
    add(16'hF0F7, 2'b01, 1'b1, 3'b000, P0, 4'd1);
    add(16'h0002, 2'b00, 1'b0, 3'b000, PERR, 4'd0);
    add(16'h0002, 2'b00, 1'b1, 3'b000, P0, 4'd0);
    add_ts1(4'd0, 4'd1);
    add(16'hF7BC, 2'b11, 1'b1, 3'b000, P0, 4'd1);
    add(16'hF0F7, 2'b01, 1'b1, 3'b000, P0, 4'd1);
    add(16'h0002, 2'b00, 1'b1, 3'b111, PERR, 4'd0);
    add_ts1(4'd0, 4'd1);
    add_ts1(4'd1, 4'd2);
    run_table("valid_status");

    // reset asserted on word 6: immediate clear, no ts_err
    apply(16'hF7BC, 2'b11, 1'b1, 3'b000);
    apply(16'hF0F7, 2'b01, 1'b1, 3'b000);
    apply(16'h0002, 2'b00, 1'b1, 3'b000);
    for (int i = 0; i < 3; i++) apply(16'h4A4A, 2'b00, 1'b1, 3'b000);
    reset = 1'b1;
    #1;
    chk("rst_mid.outs", 32'(all_outs()), 32'd0);
    chk("rst_mid.outs_hi", 32'(all_outs() >> 32), 32'd0);
    apply(16'h4A4A, 2'b00, 1'b1, 3'b000);
    chk("rst_mid.no_err", 32'(pulses()), 32'd0);
    reset = 1'b0;
    apply(16'h4A4A, 2'b00, 1'b1, 3'b000);
    chk("rst_mid.after", 32'(pulses()), 32'd0);
    add_ts1(4'd0, 4'd1);
    run_table("post_rst");
    chk_pad_ts1_fields("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
